// File: rtl/hdmi_tmds_decode.sv
// TMDS receive channel decoder: hunts for control-token alignment via bitslip, then decodes 10b->8b.
// Optional lock-loss counter port enabled by defining HDMI_TMDS_DEC_LOCKLOSS_CNT_EN.
module hdmi_tmds_decode #(
   parameter int CTRL_RUN       = 8,
   parameter int SEARCH_TIMEOUT = 1024,
   parameter int BITSLIP_WAIT   = 16
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic [9:0] sym_in,
   output logic       bitslip,
   output logic       locked,
   output logic [7:0] data_out,
   output logic       de,
   output logic       c0,
   output logic       c1
`ifdef HDMI_TMDS_DEC_LOCKLOSS_CNT_EN
   ,output logic [7:0] lockloss_cnt
`endif
);

   localparam int MAXP = (CTRL_RUN > SEARCH_TIMEOUT) ?
                         ((CTRL_RUN > BITSLIP_WAIT) ? CTRL_RUN : BITSLIP_WAIT) :
                         ((SEARCH_TIMEOUT > BITSLIP_WAIT) ? SEARCH_TIMEOUT : BITSLIP_WAIT);
   localparam int CW = $clog2(MAXP) + 1;

   typedef enum logic [1:0] {
      ST_SEARCH,
      ST_SLIP,
      ST_WAIT,
      ST_LOCKED
   } state_t;

   state_t        state, state_nxt;
   logic [9:0]    s1;
   logic [CW-1:0] run_cnt, run_nxt, run_inc;
   logic [CW-1:0] tmo_cnt, tmo_nxt;
   logic [CW-1:0] wait_cnt, wait_nxt;
   logic          tok;
   logic [1:0]    tok_c;
   logic [7:0]    d, dec;
   logic          timeout;
   logic          out_en;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         s1 <= '0;
      end else begin
         s1 <= sym_in;
      end
   end

   // Control-token detect and 10b->8b data decode of the stage-1 symbol
   always_comb begin
      tok   = 1'b1;
      tok_c = 2'b00;
      case (s1)
         10'h354: tok_c = 2'b00;
         10'h0AB: tok_c = 2'b01;
         10'h154: tok_c = 2'b10;
         10'h2AB: tok_c = 2'b11;
         default: tok = 1'b0;
      endcase
      d      = s1[9] ? ~s1[7:0] : s1[7:0];
      dec    = 8'h00;
      dec[0] = d[0];
      for (int i = 1; i < 8; i++) begin
         dec[i] = s1[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
      end
   end

   assign run_inc = (run_cnt >= CW'(CTRL_RUN)) ? run_cnt : run_cnt + CW'(1);
   assign timeout = !tok && (tmo_cnt == CW'(SEARCH_TIMEOUT - 1));

   // Alignment FSM; SLIP and WAIT hold both counters cleared so s1 is ignored there
   always_comb begin
      state_nxt = state;
      run_nxt   = tok ? run_inc : '0;
      tmo_nxt   = tok ? '0 : tmo_cnt + CW'(1);
      wait_nxt  = '0;
      case (state)
         ST_SEARCH: begin
            if (tok && (run_inc == CW'(CTRL_RUN))) begin
               state_nxt = ST_LOCKED;
            end else if (timeout) begin
               state_nxt = ST_SLIP;
               run_nxt   = '0;
               tmo_nxt   = '0;
            end
         end
         ST_SLIP: begin
            state_nxt = ST_WAIT;
            run_nxt   = '0;
            tmo_nxt   = '0;
         end
         ST_WAIT: begin
            run_nxt  = '0;
            tmo_nxt  = '0;
            wait_nxt = wait_cnt + CW'(1);
            if (wait_cnt == CW'(BITSLIP_WAIT - 1)) begin
               state_nxt = ST_SEARCH;
               wait_nxt  = '0;
            end
         end
         ST_LOCKED: begin
            if (timeout) begin
               state_nxt = ST_SEARCH;
               run_nxt   = '0;
               tmo_nxt   = '0;
            end
         end
         default: state_nxt = ST_SEARCH;
      endcase
   end

   assign out_en = (state_nxt == ST_LOCKED);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state    <= ST_SEARCH;
         run_cnt  <= '0;
         tmo_cnt  <= '0;
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         run_cnt  <= run_nxt;
         tmo_cnt  <= tmo_nxt;
         wait_cnt <= wait_nxt;
      end
   end

   // Stage 2: outputs follow the next-state lock so lock and gating line up with the symbol edge
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         bitslip  <= 1'b0;
         locked   <= 1'b0;
         de       <= 1'b0;
         data_out <= 8'h00;
         c0       <= 1'b0;
         c1       <= 1'b0;
      end else begin
         bitslip <= (state_nxt == ST_SLIP);
         locked  <= out_en;
         if (!out_en) begin
            de       <= 1'b0;
            data_out <= 8'h00;
            c0       <= 1'b0;
            c1       <= 1'b0;
         end else if (tok) begin
            de       <= 1'b0;
            data_out <= 8'h00;
            c0       <= tok_c[0];
            c1       <= tok_c[1];
         end else begin
            de       <= 1'b1;
            data_out <= dec;
         end
      end
   end

`ifdef HDMI_TMDS_DEC_LOCKLOSS_CNT_EN
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         lockloss_cnt <= 8'h00;
      end else if ((state == ST_LOCKED) && (state_nxt == ST_SEARCH) && (lockloss_cnt != 8'hFF)) begin
         lockloss_cnt <= lockloss_cnt + 8'h01;
      end
   end
`endif

endmodule

// File: tb/tb_hdmi_tmds_decode.sv
// Scoreboard bench for hdmi_tmds_decode: encoder-derived decode table plus a per-symbol alignment model.
module tb_hdmi_tmds_decode;

   localparam int CR = 8;
   localparam int ST = 16;
   localparam int BW = 4;

   logic       sys_clk = 1'b0;
   logic       sys_rst_n;
   logic [9:0] sym_in;
   logic       bitslip, locked, de, c0, c1;
   logic [7:0] data_out;
`ifdef HDMI_TMDS_DEC_LOCKLOSS_CNT_EN
   logic [7:0] lockloss_cnt;
`endif

   hdmi_tmds_decode #(
      .CTRL_RUN(CR),
      .SEARCH_TIMEOUT(ST),
      .BITSLIP_WAIT(BW)
   ) dut (
      .sys_clk(sys_clk),
      .sys_rst_n(sys_rst_n),
      .sym_in(sym_in),
      .bitslip(bitslip),
      .locked(locked),
      .data_out(data_out),
      .de(de),
      .c0(c0),
      .c1(c1)
`ifdef HDMI_TMDS_DEC_LOCKLOSS_CNT_EN
      ,.lockloss_cnt(lockloss_cnt)
`endif
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct {
      int         due;
      logic       lk;
      logic       bs;
      logic       de;
      logic       c0;
      logic       c1;
      logic [7:0] data;
      int         loss;
   } exp_t;

   exp_t       sb[$];
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   logic [7:0] dec_tab[1024];
   logic [9:0] tok_sym[4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

   bit   m_locked;
   int   m_run, m_quiet, m_blind, m_loss;
   logic m_c0, m_c1;

   function automatic int tokIdx(input logic [9:0] s);
      for (int i = 0; i < 4; i++) if (tok_sym[i] == s) return i;
      return -1;
   endfunction

   // Every 10-bit symbol is some byte run through the TMDS encoder in one of its two modes and polarities
   task automatic buildDecodeTable();
      logic [7:0] q, dv;
      logic [9:0] s;
      for (int dbyte = 0; dbyte < 256; dbyte++) begin
         dv = 8'(dbyte);
         for (int xm = 0; xm < 2; xm++) begin
            q[0] = dv[0];
            for (int i = 1; i < 8; i++) q[i] = (xm == 1) ? (q[i-1] ^ dv[i]) : ~(q[i-1] ^ dv[i]);
            for (int inv = 0; inv < 2; inv++) begin
               s = {1'(inv), 1'(xm), (inv == 1) ? ~q : q};
               dec_tab[s] = dv;
            end
         end
      end
   endtask

   task automatic modelReset();
      m_locked = 0; m_run = 0; m_quiet = 0; m_blind = 0; m_loss = 0;
      m_c0 = 0; m_c1 = 0;
   endtask

   task automatic modelStep(input logic [9:0] s, output exp_t e);
      int  ti;
      bit  tk, timed_out;
      ti = tokIdx(s);
      tk = (ti >= 0);
      e.bs = 0;
      if (m_blind > 0) begin
         m_blind--;
         m_run = 0;
         m_quiet = 0;
      end else begin
         timed_out = !tk && (m_quiet == ST - 1);
         m_quiet = tk ? 0 : m_quiet + 1;
         m_run = tk ? ((m_run + 1 > CR) ? CR : m_run + 1) : 0;
         if (!m_locked) begin
            if (tk && m_run == CR) m_locked = 1;
            else if (timed_out) begin
               e.bs = 1;
               m_blind = 1 + BW;
               m_run = 0;
               m_quiet = 0;
            end
         end else if (timed_out) begin
            m_locked = 0;
            m_run = 0;
            m_quiet = 0;
            if (m_loss < 255) m_loss++;
         end
      end
      e.lk = m_locked;
      if (!m_locked) begin
         m_c0 = 0; m_c1 = 0;
         e.de = 0; e.data = 8'h00;
      end else if (tk) begin
         m_c0 = ti[0]; m_c1 = ti[1];
         e.de = 0; e.data = 8'h00;
      end else begin
         e.de = 1; e.data = dec_tab[s];
      end
      e.c0 = m_c0;
      e.c1 = m_c1;
      e.loss = m_loss;
   endtask

   task automatic checkOutput(input string name, input exp_t e);
      int loss_act;
      loss_act = e.loss;
`ifdef HDMI_TMDS_DEC_LOCKLOSS_CNT_EN
      loss_act = int'(lockloss_cnt);
`endif
      checks++;
      if (locked !== e.lk || bitslip !== e.bs || de !== e.de || c0 !== e.c0 ||
          c1 !== e.c1 || data_out !== e.data || loss_act != e.loss) begin
         errors++;
         $display("[TB] FAIL %s @cyc %0d: got lk=%b bs=%b de=%b c1c0=%b%b data=%h loss=%0d, expected lk=%b bs=%b de=%b c1c0=%b%b data=%h loss=%0d",
                  name, cyc, locked, bitslip, de, c1, c0, data_out, loss_act,
                  e.lk, e.bs, e.de, e.c1, e.c0, e.data, e.loss);
      end
   endtask

   // Drives one symbol at a falling edge; its decoded result is due two rising edges later
   task automatic applyStimulus(input logic [9:0] s);
      exp_t e;
      sym_in = s;
      modelStep(s, e);
      e.due = cyc + 2;
      sb.push_back(e);
      @(negedge sys_clk);
   endtask

   task automatic doReset(input string name);
      exp_t z;
      #2 sys_rst_n = 1'b0;
      sb.delete();
      modelReset();
      #1;
      z = '{due: 0, lk: 0, bs: 0, de: 0, c0: 0, c1: 0, data: 8'h00, loss: 0};
      checkOutput(name, z);
      repeat (2) @(negedge sys_clk);
      sys_rst_n = 1'b1;
      modelStep(10'h000, z);
      z.due = cyc + 1;
      sb.push_back(z);
   endtask

   function automatic logic [9:0] randData();
      logic [9:0] s;
      do s = 10'($urandom_range(0, 1023)); while (tokIdx(s) >= 0);
      return s;
   endfunction

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge sys_clk);
         cyc++;
         #1;
         while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            checkOutput("stream", e);
         end
      end
   end

   initial begin : driver
      int nt, nd;
      buildDecodeTable();
      modelReset();
      sys_rst_n = 1'b0;
      sym_in = 10'h000;
      repeat (2) @(negedge sys_clk);
      doReset("reset_state");

      repeat (CR) applyStimulus(10'h354);
      applyStimulus(10'h100);
      applyStimulus(10'h200);
      applyStimulus(10'h0AB);
      repeat (ST) applyStimulus(randData());
      repeat (3) applyStimulus(10'h2AB);

      doReset("reset_slip");
      repeat (60) applyStimulus(10'h100);

      doReset("reset_broken");
      repeat (CR - 1) applyStimulus(10'h154);
      applyStimulus(10'h100);
      repeat (CR) applyStimulus(10'h154);
      repeat (4) applyStimulus(randData());

      $display("[TB] async reset while locked");
      doReset("async_reset");
      repeat (CR) applyStimulus(10'h354);
      repeat (2) applyStimulus(randData());

      for (int b = 0; b < 40; b++) begin
         nt = $urandom_range(0, 10);
         nd = $urandom_range(0, 20);
         for (int i = 0; i < nt; i++) applyStimulus(tok_sym[$urandom_range(0, 3)]);
         for (int i = 0; i < nd; i++) applyStimulus(randData());
      end

      repeat (CR) applyStimulus(10'h0AB);
      repeat (ST + 2) applyStimulus(randData());

      repeat (4) @(negedge sys_clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain: %0d expected results never compared, required 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hdmi_tmds_decode.md
# hdmi_tmds_decode

Receive-side TMDS channel decoder, the counterpart of the transmit-path 8b/10b encoder and serializer chain. It takes one deserialized 10-bit TMDS symbol per pixel clock and finds word alignment by hunting for control tokens, pulsing `bitslip` to the upstream deserializer until alignment is found. Once locked, it decodes 10b→8b data and the control pair `c0`/`c1`. One instance sits per colour channel between the deserializer and the RX video-timing logic.

## Interface
- `CTRL_RUN`, 8: consecutive control tokens required to declare lock (≥2).
- `SEARCH_TIMEOUT`, 1024: cycles without a control token before a slip (SEARCH) or loss of lock (LOCKED).
- `BITSLIP_WAIT`, 16: settle cycles after each `bitslip` pulse.
- `sys_clk` in 1: pixel clock (1x); all logic on its rising edge.
- `sys_rst_n` in 1: reset, asynchronous assert, active-low.
- `sym_in` in 10: deserialized symbol; bit 0 is first on the wire.
- `bitslip` out 1: one-cycle pulse requesting a one-bit word shift.
- `locked` out 1: alignment achieved.
- `data_out` out 8: decoded pixel byte.
- `de` out 1: data enable (decoded symbol is a data word).
- `c0` out 1, `c1` out 1: control bits (hsync/vsync on the blue channel).

## Operation
- Stage 1 registers `sym_in` into `s1`. Control-token detect on `s1`:
  - 0x354 → c1c0 = 00
  - 0x0AB → 01
  - 0x154 → 10
  - 0x2AB → 11
- Data decode of `s1`:
  - d = `s1[9]` ? ~`s1[7:0]` : `s1[7:0]`.
  - out[0] = d[0].
  - out[i] = `s1[8]` ? d[i]^d[i-1] : ~(d[i]^d[i-1]), for i = 1..7.
- Stage 2 registers the outputs:
  - Control token: `de`=0, `data_out`=0, `c0`/`c1` = token value.
  - Any other symbol: `de`=1, `data_out` = decoded byte, `c0`/`c1` hold their last value.
- Output gating: while `locked`=0, stage 2 is forced to `de`=0, `data_out`=0, `c0`=`c1`=0.
- Counters:
  - Run counter: +1 per control token on `s1`, cleared on a non-token, saturates at `CTRL_RUN`.
  - Timeout counter: cleared on each token, otherwise +1.
- FSM:
  - SEARCH: when the run reaches `CTRL_RUN`, go to LOCKED. If the timeout counter reaches `SEARCH_TIMEOUT`-1, go to SLIP. Lock check has priority over timeout in the same cycle.
  - SLIP: `bitslip`=1 for exactly one cycle, then go to WAIT.
  - WAIT: count `BITSLIP_WAIT` cycles and ignore `s1`, then go to SEARCH with both counters cleared.
  - LOCKED: `locked`=1. If the timeout counter reaches `SEARCH_TIMEOUT`-1, go to SEARCH with counters cleared; no slip on this exit.
- Counter widths are $clog2 of the largest parameter, plus 1.

## Timing
- Reset values: all outputs 0, FSM in SEARCH, counters 0, `s1` = 0.
- Reset mid-operation drops `locked` and the outputs asynchronously.
- Latency: `sym_in` at edge N appears decoded on the outputs after edge N+2.
- `locked` rises on the same edge that outputs the `CTRL_RUN`-th consecutive token, i.e. 2 cycles after that token is on `sym_in`.
- `locked` falls on the same edge at which the first gated (all-zero) output appears.
- `bitslip` pulses once per SEARCH_TIMEOUT+1+BITSLIP_WAIT cycles while no alignment is found.

## Configuration
- Macro: `HDMI_TMDS_DEC_LOCKLOSS_CNT_EN`.
- Defined:
  - Adds output port `lockloss_cnt` [7:0], reset 0.
  - Increments on each LOCKED→SEARCH transition and saturates at 255.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

## Test plan
- Lock: reset, then 8× 0x354 on `sym_in` → `locked`=1 and `c1c0`=00 two cycles after the 8th token; `bitslip` stays 0.
- Decode: locked, then drive 0x100, 0x200, 0x0AB → outputs in order:
  - `de`=1, `data_out`=0x00
  - `de`=1, `data_out`=0xFF
  - `de`=0, `c0`=1, `c1`=0, `data_out`=0
- Slip (SEARCH_TIMEOUT=16, BITSLIP_WAIT=4): constant 0x100 from reset → `bitslip` pulses once after 16 cycles, again after 21 more; `locked`=0 and `de`=0 throughout.
- Broken run: 7× 0x154, 1× 0x100, 8× 0x154 → `locked` rises only after the second run.
- Loss of lock (SEARCH_TIMEOUT=16): lock, then 16 data symbols → `locked` falls and the outputs are gated to zero with no `bitslip`. With `HDMI_TMDS_DEC_LOCKLOSS_CNT_EN` defined, `lockloss_cnt`=1.
- Async reset while locked → all outputs 0 immediately; the FSM relocks after 8 tokens.
